node_injector: RTL and testbench
================================

Name: node_injector

Overview:
- Source end of the ring: accepts locally generated packets from the host, queues them, and injects them into the node controller as self-sourced instructions.
- Sits between the upstream neighbour's outputs and the local node controller's inputs.
- Packets arriving from the ring always pass through first. Local packets fill only idle slots.
- Builds the 32-bit instruction word as {dest[2:0], NODE_IP[2:0], payload[25:0]}.

Parameters:
- NODE_IP, 3'b000, this node's ring address; placed in bits [28:26] of every injected word.
- FIFO_DEPTH, 4, host queue entries; power of 2, minimum 2.
- GAP_CYCLES, 1, idle slots forced after each injection before the next local injection; 0 disables the gap.
- STARVE_LIMIT, 8, consecutive blocked cycles with a non-empty queue before the starved flag asserts.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-high reset.
- host_valid  in  1  host offers a packet.
- host_ready  out  1  queue can accept; equals !full (combinational).
- host_dest  in  3  destination node address.
- host_payload  in  26  packet body.
- ring_enable_in  in  1  upstream controller_enable_out (ring slot occupied).
- ring_source_in  in  2  source port tag for pass-through traffic.
- ring_instruction_in  in  32  upstream instruction_out.
- controller_enable  out  1  drives the node controller's controller_enable.
- source_port  out  2  drives the node controller's source_port.
- instruction_out  out  32  drives the node controller's instruction_in.
- fifo_count  out  $clog2(FIFO_DEPTH)+1  entries currently queued.
- starved  out  1  local traffic blocked for at least STARVE_LIMIT cycles.

Behaviour:
- Reset (async, active-high):
  - controller_enable=0, source_port=2'b00, instruction_out=0, starved=0.
  - Queue emptied, so fifo_count=0 and host_ready=1.
  - State=IDLE; gap and starve counters cleared.
  - Reset mid-operation discards all queued packets. A packet driven during reset is not captured.
- Push: on a clk edge with host_valid && host_ready, {host_dest, host_payload} is written at the tail.
- Full queue: host_ready=0 and host_valid is ignored; no overwrite.
- Slot decision is made each clk edge. All outputs are registered.
  1. If ring_enable_in=1 (pass-through, highest priority):
     - controller_enable<=1, source_port<=ring_source_in, instruction_out<=ring_instruction_in.
     - No pop.
  2. Else if state=ARB (queue non-empty, gap expired), inject:
     - controller_enable<=1, source_port<=2'b01.
     - instruction_out<={head.dest, NODE_IP, head.payload}.
     - Pop the head.
  3. Else: controller_enable<=0; source_port and instruction_out hold their last values.
- Latency: push at edge N into an empty queue, with a free ring slot and no gap, gives controller_enable=1 after edge N+1.
- Simultaneous push and pop: allowed when not full; fifo_count unchanged. Pointers wrap modulo FIFO_DEPTH.
- State machine:
  - IDLE: queue empty. Go to ARB when fifo_count becomes non-zero.
  - ARB: waiting for a free slot. On injection:
    - go to GAP if GAP_CYCLES>0;
    - else stay in ARB if entries remain, otherwise go to IDLE.
  - GAP: gap counter loads GAP_CYCLES on injection and decrements each cycle. Pass-through continues during GAP. At zero, go to ARB if the queue is non-empty, else IDLE.
- Starve counter: increments each cycle in ARB while ring_enable_in=1, saturating at STARVE_LIMIT. starved=1 when counter==STARVE_LIMIT. Counter and flag clear on the cycle of an injection.
- Self-addressed packets (dest==NODE_IP) are injected normally; the node controller delivers them locally.
- Packet order is strict FIFO; no reordering.

Optional Feature:
- Macro: NODE_INJECTOR_COUNT_EN.
- Defined:
  - Adds output inject_count (16 bits), reset to 0, incremented on every local injection, wrapping 16'hFFFF -> 0.
  - Adds output drop_attempts (16 bits), counting cycles with host_valid=1 and host_ready=0, saturating at 16'hFFFF.
- Undefined: neither port nor counter exists. All other behaviour is identical.

Test Plan:
- Single inject (NODE_IP=3'b010, GAP_CYCLES=1): reset, push dest=3'b101, payload=26'h0000ABC, ring idle -> one cycle later controller_enable=1, source_port=2'b01, instruction_out=32'hA8000ABC; fifo_count returns to 0.
- Pass-through priority: queue holds 1 entry; ring_enable_in=1 for 3 cycles with ring_instruction_in=32'h60000001, ring_source_in=2'b00 -> outputs forward that word with source_port=2'b00 for 3 cycles; local packet appears on the 4th cycle.
- Full queue: push 5 back-to-back with ring busy (FIFO_DEPTH=4) -> host_ready=0 after the 4th push; 5th not captured; fifo_count=4; after the ring frees, packets exit in push order.
- Gap enforcement (GAP_CYCLES=2): 3 queued, ring idle -> injections on cycles t, t+3, t+6, with controller_enable=0 in between.
- Starvation: 1 queued, ring_enable_in=1 for 10 cycles (STARVE_LIMIT=8) -> starved=1 from the 8th blocked cycle; clears when the packet injects.
- Async reset mid-operation: assert reset between clk edges with 3 queued -> outputs 0 immediately; fifo_count=0; host_ready=1; no injection after release until a new push.

Source files
------------

// File: rtl/node_injector_if.sv
`default_nettype none
// ============================================================================
//  Module      : node_injector_if
//  Description : Bundles the host-side push port, the upstream ring inputs and
//                the node-controller-facing outputs of node_injector. The
//                optional statistics signals exist only when
//                NODE_INJECTOR_COUNT_EN is defined.
//  Revision    : 1.0 - initial release
// ============================================================================
interface node_injector_if #(
    parameter int FIFO_DEPTH = 4
);
    localparam int c_CNT_W = $clog2(FIFO_DEPTH) + 1;

    // Host push port
    logic                host_valid;
    logic                host_ready;
    logic [2:0]          host_dest;
    logic [25:0]         host_payload;

    // Upstream ring inputs
    logic                ring_enable_in;
    logic [1:0]          ring_source_in;
    logic [31:0]         ring_instruction_in;

    // Node controller outputs and status
    logic                controller_enable;
    logic [1:0]          source_port;
    logic [31:0]         instruction_out;
    logic [c_CNT_W-1:0]  fifo_count;
    logic                starved;
`ifdef NODE_INJECTOR_COUNT_EN
    logic [15:0]         inject_count;
    logic [15:0]         drop_attempts;
`endif

    // Host / ring / environment side
    modport master (
        output host_valid,
        output host_dest,
        output host_payload,
        output ring_enable_in,
        output ring_source_in,
        output ring_instruction_in,
        input  host_ready,
        input  controller_enable,
        input  source_port,
        input  instruction_out,
        input  fifo_count,
        input  starved
`ifdef NODE_INJECTOR_COUNT_EN
        ,
        input  inject_count,
        input  drop_attempts
`endif
    );

    // Injector side
    modport slave (
        input  host_valid,
        input  host_dest,
        input  host_payload,
        input  ring_enable_in,
        input  ring_source_in,
        input  ring_instruction_in,
        output host_ready,
        output controller_enable,
        output source_port,
        output instruction_out,
        output fifo_count,
        output starved
`ifdef NODE_INJECTOR_COUNT_EN
        ,
        output inject_count,
        output drop_attempts
`endif
    );
endinterface
`default_nettype wire

// File: rtl/node_injector.sv
`default_nettype none
// ============================================================================
//  Module      : node_injector
//  Description : Ring source stage. Queues host packets and injects them into
//                the local node controller in slots the upstream ring leaves
//                idle. Ring traffic always has priority. Injected words are
//                {dest[2:0], NODE_IP[2:0], payload[25:0]} with source_port 01.
//                Optional statistics (inject_count, drop_attempts) are built
//                when NODE_INJECTOR_COUNT_EN is defined.
//  Revision    : 1.0 - initial release
// ============================================================================
module node_injector #(
    parameter logic [2:0] NODE_IP      = 3'b000,
    parameter int         FIFO_DEPTH   = 4,
    parameter int         GAP_CYCLES   = 1,
    parameter int         STARVE_LIMIT = 8
) (
    input wire              clk,
    input wire              reset,
    node_injector_if.slave  bus
);

    localparam int c_PTR_W = $clog2(FIFO_DEPTH);
    localparam int c_CNT_W = c_PTR_W + 1;
    localparam int c_GAP_W = (GAP_CYCLES > 0) ? $clog2(GAP_CYCLES + 1) : 1;
    localparam int c_STV_W = $clog2(STARVE_LIMIT + 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ARB  = 2'd1,
        S_GAP  = 2'd2
    } state_t;

    // Queue entry layout: {dest[2:0], payload[25:0]}
    logic [28:0]         fifo_mem [FIFO_DEPTH];
    logic [c_PTR_W-1:0]  wr_ptr_q;
    logic [c_PTR_W-1:0]  rd_ptr_q;
    logic [c_CNT_W-1:0]  count_q, count_d;

    state_t              state_q, state_d;
    logic [c_GAP_W-1:0]  gap_q, gap_d;
    logic [c_STV_W-1:0]  starve_q, starve_d;
    logic                starved_q, starved_d;

    logic                en_q, en_d;
    logic [1:0]          src_q, src_d;
    logic [31:0]         instr_q, instr_d;

    logic                w_full;
    logic                w_push;
    logic                w_inject;
    logic [28:0]         w_head;

    assign w_full   = (count_q == c_CNT_W'(FIFO_DEPTH));
    assign w_push   = bus.host_valid && !w_full;
    // A local slot exists only when the ring leaves this cycle empty
    assign w_inject = (state_q == S_ARB) && !bus.ring_enable_in;
    assign w_head   = fifo_mem[rd_ptr_q];

    // Queue storage: written at the tail on an accepted push
    always_ff @(posedge clk) begin
        if (w_push) begin
            fifo_mem[wr_ptr_q] <= {bus.host_dest, bus.host_payload};
        end
    end

    // Queue pointers and occupancy
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (w_push) begin
                wr_ptr_q <= wr_ptr_q + c_PTR_W'(1);
            end
            if (w_inject) begin
                rd_ptr_q <= rd_ptr_q + c_PTR_W'(1);
            end
            count_q <= count_d;
        end
    end

    // Slot decision, state machine and starvation tracking
    always_comb begin
        count_d   = count_q;
        state_d   = state_q;
        gap_d     = gap_q;
        starve_d  = starve_q;
        en_d      = 1'b0;
        src_d     = src_q;
        instr_d   = instr_q;

        case ({w_push, w_inject})
            2'b10:   count_d = count_q + c_CNT_W'(1);
            2'b01:   count_d = count_q - c_CNT_W'(1);
            default: count_d = count_q;
        endcase

        if (bus.ring_enable_in) begin
            en_d    = 1'b1;
            src_d   = bus.ring_source_in;
            instr_d = bus.ring_instruction_in;
        end else if (w_inject) begin
            en_d    = 1'b1;
            src_d   = 2'b01;
            instr_d = {w_head[28:26], NODE_IP, w_head[25:0]};
        end

        case (state_q)
            S_IDLE: begin
                if (count_d != '0) begin
                    state_d = S_ARB;
                end
            end
            S_ARB: begin
                if (w_inject) begin
                    starve_d = '0;
                    if (GAP_CYCLES > 0) begin
                        state_d = S_GAP;
                        gap_d   = c_GAP_W'(GAP_CYCLES);
                    end else begin
                        state_d = (count_d != '0) ? S_ARB : S_IDLE;
                    end
                end else if (starve_q != c_STV_W'(STARVE_LIMIT)) begin
                    // In ARB without injecting means the ring held the slot
                    starve_d = starve_q + c_STV_W'(1);
                end
            end
            S_GAP: begin
                gap_d = gap_q - c_GAP_W'(1);
                if (gap_q <= c_GAP_W'(1)) begin
                    state_d = (count_d != '0) ? S_ARB : S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        starved_d = (starve_d == c_STV_W'(STARVE_LIMIT));
    end

    // Registered state and outputs
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= S_IDLE;
            gap_q     <= '0;
            starve_q  <= '0;
            starved_q <= 1'b0;
            en_q      <= 1'b0;
            src_q     <= 2'b00;
            instr_q   <= '0;
        end else begin
            state_q   <= state_d;
            gap_q     <= gap_d;
            starve_q  <= starve_d;
            starved_q <= starved_d;
            en_q      <= en_d;
            src_q     <= src_d;
            instr_q   <= instr_d;
        end
    end

    assign bus.host_ready        = !w_full;
    assign bus.controller_enable = en_q;
    assign bus.source_port       = src_q;
    assign bus.instruction_out   = instr_q;
    assign bus.fifo_count        = count_q;
    assign bus.starved           = starved_q;

`ifdef NODE_INJECTOR_COUNT_EN
    logic [15:0] inject_count_q;
    logic [15:0] drop_attempts_q;

    // Injection counter wraps; drop counter saturates
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            inject_count_q  <= '0;
            drop_attempts_q <= '0;
        end else begin
            if (w_inject) begin
                inject_count_q <= inject_count_q + 16'd1;
            end
            if (bus.host_valid && w_full && (drop_attempts_q != 16'hFFFF)) begin
                drop_attempts_q <= drop_attempts_q + 16'd1;
            end
        end
    end

    assign bus.inject_count  = inject_count_q;
    assign bus.drop_attempts = drop_attempts_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_node_injector.sv
`default_nettype none
// ============================================================================
//  Module      : tb_node_injector
//  Description : Randomised and directed stimulus for node_injector with a
//                slot-level reference model and an output scoreboard.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_node_injector;

    localparam logic [2:0] NODE_IP      = 3'b010;
    localparam int         DEPTH        = 4;
    localparam int         GAP          = 2;
    localparam int         LIMIT        = 8;

    logic clk   = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    node_injector_if #(.FIFO_DEPTH(DEPTH)) bus ();

    node_injector #(
        .NODE_IP      (NODE_IP),
        .FIFO_DEPTH   (DEPTH),
        .GAP_CYCLES   (GAP),
        .STARVE_LIMIT (LIMIT)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct packed {
        logic [1:0]  src;
        logic [31:0] instr;
    } out_t;

    int   checks = 0;
    int   errors = 0;
    bit   done   = 1'b0;

    // Reference model state
    logic [28:0] m_q [$];
    out_t        exp_q [$];
    int          cyc;
    int          last_inj;
    int          starve_cnt;
    int          n_inj;
    logic [1:0]  m_src;
    logic [31:0] m_instr;

    function automatic void chk(string name, logic [31:0] act, logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, req);
        end
    endfunction

    // Slot-level model: a local packet may go out once it was queued before
    // this edge and at least GAP idle slots followed the previous injection.
    initial begin
        forever begin
            @(posedge clk or posedge reset);
            if (reset) begin
                m_q.delete();
                exp_q.delete();
                cyc        = 0;
                last_inj   = -100;
                starve_cnt = 0;
                n_inj      = 0;
                m_src      = 2'b00;
                m_instr    = 32'h0;
            end else begin
                bit          accept;
                bit          elig;
                logic [28:0] head;
                cyc++;
                accept = bus.host_valid && (m_q.size() < DEPTH);
                elig   = (m_q.size() > 0) && (cyc >= last_inj + GAP + 1);
                if (bus.ring_enable_in) begin
                    m_src   = bus.ring_source_in;
                    m_instr = bus.ring_instruction_in;
                    exp_q.push_back('{m_src, m_instr});
                    if (elig && starve_cnt < LIMIT) starve_cnt++;
                end else if (elig) begin
                    head    = m_q.pop_front();
                    m_src   = 2'b01;
                    m_instr = {head[28:26], NODE_IP, head[25:0]};
                    exp_q.push_back('{m_src, m_instr});
                    last_inj   = cyc;
                    starve_cnt = 0;
                    n_inj++;
                end
                if (accept) m_q.push_back({bus.host_dest, bus.host_payload});
            end
        end
    end

    // Monitor: compares DUT outputs against the model on every falling edge
    initial begin
        out_t e;
        while (!done) begin
            @(negedge clk);
            if (reset) begin
                chk("rst_enable",      32'(bus.controller_enable), 32'd0);
                chk("rst_source_port", 32'(bus.source_port),       32'd0);
                chk("rst_instruction", bus.instruction_out,        32'd0);
                chk("rst_starved",     32'(bus.starved),           32'd0);
                chk("rst_fifo_count",  32'(bus.fifo_count),        32'd0);
                chk("rst_host_ready",  32'(bus.host_ready),        32'd1);
            end else begin
                chk("fifo_count",  32'(bus.fifo_count), 32'(m_q.size()));
                chk("host_ready",  32'(bus.host_ready), 32'(m_q.size() < DEPTH));
                chk("starved",     32'(bus.starved),    32'(starve_cnt == LIMIT));
                chk("source_port", 32'(bus.source_port), 32'(m_src));
                chk("instruction_out", bus.instruction_out, m_instr);
                chk("controller_enable", 32'(bus.controller_enable), 32'(exp_q.size() != 0));
                if (exp_q.size() != 0) begin
                    e = exp_q.pop_front();
                    if (bus.controller_enable) begin
                        chk("stream_source", 32'(bus.source_port), 32'(e.src));
                        chk("stream_instr",  bus.instruction_out,  e.instr);
                    end
                end
            end
        end
        chk("pending_outputs", 32'(exp_q.size()), 32'd0);
`ifdef NODE_INJECTOR_COUNT_EN
        chk("inject_count", 32'(bus.inject_count), 32'(16'(n_inj)));
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // Drive one cycle's inputs, then advance to just after the next edge
    task automatic drive(input bit v, input logic [2:0] d, input logic [25:0] p,
                         input bit re, input logic [1:0] rs, input logic [31:0] ri);
        bus.host_valid          = v;
        bus.host_dest           = d;
        bus.host_payload        = p;
        bus.ring_enable_in      = re;
        bus.ring_source_in      = rs;
        bus.ring_instruction_in = ri;
        @(posedge clk);
        #2;
    endtask

    task automatic idle(input int n);
        repeat (n) drive(1'b0, 3'd0, 26'd0, 1'b0, 2'b00, 32'h0);
    endtask

    initial begin
        bus.host_valid          = 1'b0;
        bus.host_dest           = 3'd0;
        bus.host_payload        = 26'd0;
        bus.ring_enable_in      = 1'b0;
        bus.ring_source_in      = 2'b00;
        bus.ring_instruction_in = 32'h0;
        #1 reset = 1'b1;
        repeat (3) @(posedge clk);
        #2 reset = 1'b0;

        // Single injection of dest 5 / payload ABC
        drive(1'b1, 3'b101, 26'h0000ABC, 1'b0, 2'b00, 32'h0);
        idle(4);

        // Ring traffic holds off a queued packet
        drive(1'b1, 3'b011, 26'h0001234, 1'b1, 2'b00, 32'h60000001);
        repeat (3) drive(1'b0, 3'd0, 26'd0, 1'b1, 2'b00, 32'h60000001);
        idle(4);

        // Overfill the queue while the ring is busy
        for (int i = 0; i < 5; i++)
            drive(1'b1, 3'(i), 26'(32'h100 + i), 1'b1, 2'b10, 32'h20000000 + i);
        repeat (3) drive(1'b0, 3'd0, 26'd0, 1'b1, 2'b11, 32'h3000000F);
        idle(14);

        // Three queued packets drained with enforced gaps
        for (int i = 0; i < 3; i++)
            drive(1'b1, 3'(i + 4), 26'(32'h200 + i), 1'b1, 2'b00, 32'h40000000 + i);
        idle(12);

        // Starvation: one packet blocked for 10 slots
        drive(1'b1, NODE_IP, 26'h3FFFFFF, 1'b1, 2'b10, 32'h11111111);
        repeat (10) drive(1'b0, 3'd0, 26'd0, 1'b1, 2'b10, 32'h22222222);
        idle(5);

        // Random traffic
        repeat (400)
            drive(1'($urandom_range(0, 1)), 3'($urandom), 26'($urandom),
                  ($urandom_range(0, 99) < 40), 2'($urandom), 32'($urandom));
        idle(10);

        // Asynchronous reset with packets queued
        for (int i = 0; i < 3; i++)
            drive(1'b1, 3'(i), 26'(32'h300 + i), 1'b1, 2'b00, 32'h55555555);
        #1 reset = 1'b1;
        bus.host_valid = 1'b1;
        @(posedge clk);
        #2;
        bus.host_valid     = 1'b0;
        bus.ring_enable_in = 1'b0;
        reset = 1'b0;
        idle(6);
        drive(1'b1, 3'b111, 26'h0C0FFEE, 1'b0, 2'b00, 32'h0);
        idle(5);

        done = 1'b1;
    end

    // Hard stop in case the monitor never reaches its summary
    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1);
    end

endmodule
`default_nettype wire
